// File: rtl/wb_port_arbiter.sv
// Shares the regfile write port between pipeline writeback and a long-latency unit.
// LU results queue in a small in-order buffer and drain into idle write-port cycles.
module wb_port_arbiter #(
  parameter int XLEN       = 32,
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pipe_regwen,
  input  logic [4:0]      pipe_rd,
  input  logic [XLEN-1:0] pipe_wdata,
  input  logic            lu_valid,
  output logic            lu_ready,
  input  logic [4:0]      lu_rd,
  input  logic [XLEN-1:0] lu_wdata,
  input  logic [4:0]      chk_rs1,
  input  logic [4:0]      chk_rs2,
  output logic            hazard,
  output logic            stall_req,
  output logic            rf_we,
  output logic [4:0]      rf_wa,
  output logic [XLEN-1:0] rf_wd
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [4:0]      q_rd   [DEPTH];
  logic [XLEN-1:0] q_data [DEPTH];
  logic [CW-1:0]   q_cnt;
  logic [4:0]      n_rd   [DEPTH];
  logic [XLEN-1:0] n_data [DEPTH];
  logic [CW-1:0]   n_cnt;
  logic [SW-1:0]   starve_cnt;
  logic            rf_lu;
  logic            pipe_wr;
  logic            fifo_ne;
  logic            take_fifo;
  logic            squash;
  logic            enq;
  logic            blocked;

  function automatic logic rd_hit(input logic [4:0] rd, input logic [4:0] rs1,
                                  input logic [4:0] rs2);
    return (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
  endfunction

  assign lu_ready  = (q_cnt < CW'(DEPTH));
  assign pipe_wr   = pipe_regwen && (pipe_rd != 5'd0);
  assign fifo_ne   = (q_cnt != '0);
  assign take_fifo = fifo_ne && (stall_req || !pipe_wr);
  assign squash    = pipe_wr && !take_fifo;
  assign enq       = lu_valid && lu_ready && (lu_rd != 5'd0);
  assign blocked   = fifo_ne && !take_fifo;

  // Queue is kept compacted at index 0 = head: drop the dequeued head and any
  // entries overwritten by a younger pipe write, then append the new LU result.
  always_comb begin
    n_cnt = '0;
    for (int k = 0; k < DEPTH; k++) begin
      n_rd[k]   = q_rd[k];
      n_data[k] = q_data[k];
    end
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < q_cnt) && !(take_fifo && (i == 0)) &&
          !(squash && (q_rd[i] == pipe_rd))) begin
        for (int k = 0; k < DEPTH; k++) begin
          if (CW'(k) == n_cnt) begin
            n_rd[k]   = q_rd[i];
            n_data[k] = q_data[i];
          end
        end
        n_cnt = n_cnt + CW'(1);
      end
    end
    if (enq) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (CW'(k) == n_cnt) begin
          n_rd[k]   = lu_rd;
          n_data[k] = lu_wdata;
        end
      end
      n_cnt = n_cnt + CW'(1);
    end
  end

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < q_cnt) && rd_hit(q_rd[i], chk_rs1, chk_rs2)) hazard = 1'b1;
    end
    if (rf_lu && rd_hit(rf_wa, chk_rs1, chk_rs2)) hazard = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_cnt <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        q_rd[k]   <= '0;
        q_data[k] <= '0;
      end
    end else begin
      q_cnt <= n_cnt;
      for (int k = 0; k < DEPTH; k++) begin
        q_rd[k]   <= n_rd[k];
        q_data[k] <= n_data[k];
      end
    end
  end

  // rf_lu marks that the registered write came from the queue, for the hazard lookup.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we <= 1'b0;
      rf_wa <= '0;
      rf_wd <= '0;
      rf_lu <= 1'b0;
    end else if (take_fifo) begin
      rf_we <= 1'b1;
      rf_wa <= q_rd[0];
      rf_wd <= q_data[0];
      rf_lu <= 1'b1;
    end else if (pipe_wr) begin
      rf_we <= 1'b1;
      rf_wa <= pipe_rd;
      rf_wd <= pipe_wdata;
      rf_lu <= 1'b0;
    end else begin
      rf_we <= 1'b0;
      rf_lu <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
      stall_req  <= 1'b0;
    end else if (!blocked) begin
      starve_cnt <= '0;
      stall_req  <= 1'b0;
    end else if (starve_cnt == SW'(STARVE_MAX - 1)) begin
      starve_cnt <= '0;
      stall_req  <= 1'b1;
    end else begin
      starve_cnt <= starve_cnt + SW'(1);
      stall_req  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios plus random traffic, all checked
// every cycle against a queue-based reference model.
module tb_wb_port_arbiter;
  localparam int XLEN       = 32;
  localparam int DEPTH      = 2;
  localparam int STARVE_MAX = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            pipe_regwen = 1'b0;
  logic [4:0]      pipe_rd = '0;
  logic [XLEN-1:0] pipe_wdata = '0;
  logic            lu_valid = 1'b0;
  logic            lu_ready;
  logic [4:0]      lu_rd = '0;
  logic [XLEN-1:0] lu_wdata = '0;
  logic [4:0]      chk_rs1 = '0;
  logic [4:0]      chk_rs2 = '0;
  logic            hazard;
  logic            stall_req;
  logic            rf_we;
  logic [4:0]      rf_wa;
  logic [XLEN-1:0] rf_wd;

  wb_port_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .pipe_regwen(pipe_regwen), .pipe_rd(pipe_rd), .pipe_wdata(pipe_wdata),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_wdata(lu_wdata),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .hazard(hazard), .stall_req(stall_req),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } entry_t;

  entry_t          mq[$];
  int              m_run;
  logic            m_stall;
  logic            m_we;
  logic            m_lu;
  logic [4:0]      m_wa;
  logic [XLEN-1:0] m_wd;
  logic            m_taken;
  int              n_cmp = 0;
  int              n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_run = 0;
    m_stall = 1'b0;
    m_we = 1'b0;
    m_lu = 1'b0;
    m_wa = '0;
    m_wd = '0;
    m_taken = 1'b0;
  endtask

  function automatic logic model_hazard();
    logic h;
    h = 1'b0;
    foreach (mq[i]) if (mq[i].rd == chk_rs1 || mq[i].rd == chk_rs2) h = 1'b1;
    if (m_we && m_lu && m_wa != 5'd0 && (m_wa == chk_rs1 || m_wa == chk_rs2)) h = 1'b1;
    return h;
  endfunction

  // Check outputs mid-cycle, then advance the model by one clock edge.
  task automatic cycle();
    logic   ready, pipe_wr, take, blocked;
    entry_t e;
    entry_t keep[$];
    @(negedge clk);
    ready = (mq.size() < DEPTH);
    check_val("lu_ready", {31'd0, lu_ready}, {31'd0, ready});
    check_val("hazard", {31'd0, hazard}, {31'd0, model_hazard()});
    check_val("stall_req", {31'd0, stall_req}, {31'd0, m_stall});
    check_val("rf_we", {31'd0, rf_we}, {31'd0, m_we});
    check_val("rf_wa", {27'd0, rf_wa}, {27'd0, m_wa});
    check_val("rf_wd", rf_wd, m_wd);
    pipe_wr = pipe_regwen && (pipe_rd != 5'd0);
    take    = (mq.size() > 0) && (m_stall || !pipe_wr);
    blocked = (mq.size() > 0) && !take;
    m_taken = lu_valid && ready;
    if (take) begin
      e = mq.pop_front();
      m_we = 1'b1; m_wa = e.rd; m_wd = e.data; m_lu = 1'b1;
    end else if (pipe_wr) begin
      m_we = 1'b1; m_wa = pipe_rd; m_wd = pipe_wdata; m_lu = 1'b0;
      foreach (mq[i]) if (mq[i].rd != pipe_rd) keep.push_back(mq[i]);
      mq = keep;
    end else begin
      m_we = 1'b0; m_lu = 1'b0;
    end
    if (m_taken && lu_rd != 5'd0) begin
      e.rd = lu_rd; e.data = lu_wdata;
      mq.push_back(e);
    end
    if (blocked) begin
      m_run++;
      if (m_run == STARVE_MAX) begin
        m_stall = 1'b1; m_run = 0;
      end else m_stall = 1'b0;
    end else begin
      m_run = 0; m_stall = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic pw, input logic [4:0] prd, input logic [XLEN-1:0] pd,
                       input logic lv, input logic [4:0] lrd, input logic [XLEN-1:0] ld);
    pipe_regwen = pw; pipe_rd = prd; pipe_wdata = pd;
    lu_valid = lv; lu_rd = lrd; lu_wdata = ld;
  endtask

  initial begin
    int busy;
    bit hit;
    model_reset();
    #22;
    check_val("rst_rf_we", {31'd0, rf_we}, 32'd0);
    check_val("rst_rf_wa", {27'd0, rf_wa}, 32'd0);
    check_val("rst_rf_wd", rf_wd, 32'd0);
    check_val("rst_stall", {31'd0, stall_req}, 32'd0);
    check_val("rst_lu_ready", {31'd0, lu_ready}, 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // pipe write alone
    drive(1, 5'd5, 32'h11, 0, 0, 0); cycle();
    drive(0, 0, 0, 0, 0, 0); cycle();
    check_val("d1_wa", {27'd0, rf_wa}, 32'd5);

    // LU result into an idle port
    drive(0, 0, 0, 1, 5'd7, 32'hAA); cycle();
    drive(0, 0, 0, 0, 0, 0); cycle(); cycle();
    check_val("d2_wd", rf_wd, 32'hAA);

    // fill while the pipe writes every cycle, until the stall pulse
    drive(1, 5'd12, 32'h100, 1, 5'd3, 32'h33); cycle();
    drive(1, 5'd12, 32'h101, 1, 5'd4, 32'h44); cycle();
    drive(1, 5'd12, 32'h102, 0, 0, 0);
    check_val("d3_full", {31'd0, lu_ready}, 32'd0);
    hit = 0;
    for (int n = 0; n < 20 && !hit; n++) begin
      pipe_wdata = 32'h200 + n;
      cycle();
      hit = m_stall;
    end
    check_val("d3_stall_seen", {31'd0, stall_req}, 32'd1);
    cycle();
    check_val("d3_first_drain", {27'd0, rf_wa}, 32'd3);
    drive(0, 0, 0, 0, 0, 0); cycle(); cycle(); cycle();

    // WAW squash of a queued entry
    drive(1, 5'd1, 32'h5, 1, 5'd9, 32'h1); chk_rs1 = 5'd9; cycle();
    drive(1, 5'd9, 32'h2, 0, 0, 0); cycle();
    drive(0, 0, 0, 0, 0, 0); #1;
    check_val("d4_haz_drop", {31'd0, hazard}, 32'd0);
    check_val("d4_wd", rf_wd, 32'h2);
    cycle(); cycle();

    // hazard lookup and x0 handling
    drive(1, 5'd1, 32'h6, 1, 5'd4, 32'h44); chk_rs1 = 5'd0; cycle();
    drive(1, 5'd1, 32'h7, 0, 0, 0); chk_rs1 = 5'd4; #1;
    check_val("d5_haz", {31'd0, hazard}, 32'd1);
    cycle();
    chk_rs1 = 5'd0; #1;
    check_val("d5_haz_x0", {31'd0, hazard}, 32'd0);
    drive(0, 0, 0, 0, 0, 0); cycle(); cycle();
    drive(0, 0, 0, 1, 5'd0, 32'hDEAD); cycle();
    drive(1, 5'd0, 32'hBEEF, 0, 0, 0); cycle();
    drive(0, 0, 0, 0, 0, 0); cycle();

    // reset while two entries are queued and stall_req is high
    drive(1, 5'd12, 32'h300, 1, 5'd3, 32'h33); cycle();
    drive(1, 5'd12, 32'h301, 1, 5'd4, 32'h44); cycle();
    drive(1, 5'd12, 32'h302, 0, 0, 0);
    hit = 0;
    for (int n = 0; n < 20 && !hit; n++) begin
      cycle();
      hit = m_stall;
    end
    check_val("d6_stall_pre", {31'd0, stall_req}, 32'd1);
    chk_rs1 = 5'd3;
    #2 rst_n = 1'b0;
    #1;
    check_val("d6_rf_we", {31'd0, rf_we}, 32'd0);
    check_val("d6_rf_wa", {27'd0, rf_wa}, 32'd0);
    check_val("d6_rf_wd", rf_wd, 32'd0);
    check_val("d6_stall", {31'd0, stall_req}, 32'd0);
    check_val("d6_haz", {31'd0, hazard}, 32'd0);
    model_reset();
    drive(0, 0, 0, 0, 0, 0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    cycle();
    check_val("d6_ready", {31'd0, lu_ready}, 32'd1);

    // random traffic; the LU holds its result until accepted
    for (int n = 0; n < 3000; n++) begin
      busy = ((n / 500) % 2 == 1) ? 97 : 40;
      pipe_regwen = ($urandom_range(99) < busy);
      pipe_rd     = 5'($urandom_range(15));
      pipe_wdata  = $urandom;
      if (!(lu_valid && !m_taken)) begin
        lu_valid = ($urandom_range(2) == 0);
        lu_rd    = 5'($urandom_range(15));
        lu_wdata = $urandom;
      end
      chk_rs1 = 5'($urandom_range(15));
      chk_rs2 = 5'($urandom_range(15));
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
